// File: rtl/qs_srt_decode_queue.sv
// qs_srt decode-and-buffer stage: decodes raw instructions into microcode and queues them for issue.
// Define QS_SRT_DECODE_Q_BYPASS_EN to forward into an empty queue combinationally in the same cycle.
package qs_srt_pkg;

  typedef struct packed {
    logic [3:0]  op;
    logic        mode;      // W / SEL / store / RET / done, depending on opcode
    logic        imm_sel;
    logic        sub;
    logic        spec_sel;
    logic [3:0]  r;
    logic [3:0]  s;
    logic [3:0]  u;
    logic [11:0] i;
  } inst_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JCC   = 4'd1;
  localparam logic [3:0] OP_PP    = 4'd2;
  localparam logic [3:0] OP_MEM   = 4'd3;
  localparam logic [3:0] OP_MOV   = 4'd4;
  localparam logic [3:0] OP_ARITH = 4'd5;
  localparam logic [3:0] OP_CRET  = 4'd6;
  localparam logic [3:0] OP_CNTRL = 4'd7;
  localparam logic [3:0] BLINK    = 4'hF;

  typedef struct packed {
    logic [11:0] imm;
    logic [3:0]  dst;
    logic [3:0]  src0;
    logic [3:0]  src1;
    logic [3:0]  special;
    logic [3:0]  cc;
    logic [15:0] target;
    logic        dst_en;
    logic        src0_en;
    logic        src1_en;
    logic        src0_is_zero;
    logic        src0_is_blink;
    logic        src1_is_blink;
    logic        has_imm;
    logic        has_special;
    logic        flag_en;
    logic        inv_src1;
    logic        cin;
    logic        is_jump;
    logic        is_done;
    logic        is_await;
    logic        invalid_inst;
  } ucode_t;

endpackage

module qs_srt_decode_queue
  import qs_srt_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 8,
  parameter int ERR_CNT_W    = 8,
  parameter int DROP_INVALID = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  inst_t                      in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_rdy,
  output logic                       out_vld,
  output ucode_t                     out_ucode,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       out_rdy,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_invalid,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_invalid_q, err_invalid_d;
  ucode_t               mem_ucode_q [DEPTH];
  ucode_t               mem_ucode_d [DEPTH];
  logic [PC_W-1:0]      mem_pc_q [DEPTH];
  logic [PC_W-1:0]      mem_pc_d [DEPTH];

  ucode_t dec;
  logic   accept, inv_accept, push_cand, push, pop, stored_vld, bypass;

  always_comb begin
    dec         = '0;
    dec.imm     = in_inst.i;
    dec.dst     = in_inst.r;
    dec.src0    = in_inst.s;
    dec.src1    = in_inst.u;
    dec.special = in_inst.i[3:0];
    dec.cc      = in_inst.r;
    dec.target  = {in_inst.u, in_inst.i};
    case (in_inst.op)
      OP_NOP: ;
      OP_JCC: dec.is_jump = 1'b1;
      OP_PP: begin
        if (in_inst.mode) begin
          dec.dst_en = 1'b1;
        end else begin
          dec.src1_en      = 1'b1;
          dec.src0_is_zero = 1'b1;
        end
      end
      OP_MEM: begin
        dec.src1_en = 1'b1;
        if (in_inst.mode) dec.src0_en = 1'b1;
        else              dec.dst_en  = 1'b1;
      end
      OP_MOV: begin
        dec.dst_en       = 1'b1;
        dec.src0_is_zero = 1'b1;
        if (in_inst.imm_sel)       dec.has_imm     = 1'b1;
        else if (in_inst.spec_sel) dec.has_special = 1'b1;
        else                       dec.src1_en     = 1'b1;
      end
      OP_ARITH: begin
        dec.dst_en   = in_inst.mode;
        dec.flag_en  = 1'b1;
        dec.src0_en  = 1'b1;
        dec.has_imm  = in_inst.imm_sel;
        dec.src1_en  = !in_inst.imm_sel;
        dec.inv_src1 = in_inst.sub;
        dec.cin      = in_inst.sub;
      end
      OP_CRET: begin
        dec.is_jump      = 1'b1;
        dec.src0_is_zero = 1'b1;
        if (in_inst.mode) begin
          dec.src1    = BLINK;
          dec.src1_en = 1'b1;
        end else begin
          dec.dst    = BLINK;
          dec.dst_en = 1'b1;
        end
      end
      OP_CNTRL: begin
        dec.is_done  = in_inst.mode;
        dec.is_await = !in_inst.mode;
      end
      default: dec.invalid_inst = 1'b1;
    endcase
    dec.src0_is_blink = dec.src0_en & (dec.src0 == BLINK);
    dec.src1_is_blink = dec.src1_en & (dec.src1 == BLINK);
  end

  // Invalid instructions are accounted even when dropped or flushed away.
  always_comb begin
    in_rdy     = (occ_q != OCC_W'(DEPTH));
    stored_vld = (occ_q != '0);
    accept     = in_vld & in_rdy;
    inv_accept = accept & dec.invalid_inst;
    push_cand  = accept & !flush & !((DROP_INVALID != 0) & dec.invalid_inst);
`ifdef QS_SRT_DECODE_Q_BYPASS_EN
    bypass     = push_cand & out_rdy & !stored_vld;
`else
    bypass     = 1'b0;
`endif
    push       = push_cand & !bypass;
    pop        = stored_vld & out_rdy & !flush;

    out_vld   = stored_vld | bypass;
    out_ucode = '0;
    out_pc    = '0;
    if (bypass) begin
      out_ucode = dec;
      out_pc    = in_pc;
    end else if (stored_vld) begin
      out_ucode = mem_ucode_q[rd_ptr_q];
      out_pc    = mem_pc_q[rd_ptr_q];
    end
    occupancy   = occ_q;
    err_cnt     = err_cnt_q;
    err_invalid = err_invalid_q;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    mem_ucode_d   = mem_ucode_q;
    mem_pc_d      = mem_pc_q;
    err_cnt_d     = err_cnt_q;
    err_invalid_d = err_invalid_q | inv_accept;
    if (inv_accept && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_ucode_d[wr_ptr_q] = dec;
        mem_pc_d[wr_ptr_q]    = in_pc;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      err_cnt_q     <= '0;
      err_invalid_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_ucode_q[k] <= '0;
        mem_pc_q[k]    <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      err_cnt_q     <= err_cnt_d;
      err_invalid_q <= err_invalid_d;
      mem_ucode_q   <= mem_ucode_d;
      mem_pc_q      <= mem_pc_d;
    end
  end

endmodule

// File: tb/tb_qs_srt_decode_queue.sv
// Directed bench for qs_srt_decode_queue: one dropping/narrow-counter instance and one default instance on shared stimulus.
module tb_qs_srt_decode_queue;
  import qs_srt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  inst_t       in_inst;
  logic [7:0]  in_pc;
  logic        out_rdy;
  logic        flush;

  logic        in_rdy, out_vld, err_invalid;
  ucode_t      out_ucode;
  logic [7:0]  out_pc;
  logic [2:0]  occupancy;
  logic [1:0]  err_cnt;

  logic        b_in_rdy, b_out_vld, b_err_invalid;
  ucode_t      b_out_ucode;
  logic [7:0]  b_out_pc;
  logic [2:0]  b_occupancy;
  logic [7:0]  b_err_cnt;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  qs_srt_decode_queue #(.DEPTH(4), .PC_W(8), .ERR_CNT_W(2), .DROP_INVALID(1)) dutA (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_inst(in_inst), .in_pc(in_pc), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_ucode(out_ucode), .out_pc(out_pc), .out_rdy(out_rdy), .flush(flush),
    .occupancy(occupancy), .err_invalid(err_invalid), .err_cnt(err_cnt));

  qs_srt_decode_queue dutB (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_inst(in_inst), .in_pc(in_pc), .in_rdy(b_in_rdy),
    .out_vld(b_out_vld), .out_ucode(b_out_ucode), .out_pc(b_out_pc), .out_rdy(out_rdy), .flush(flush),
    .occupancy(b_occupancy), .err_invalid(b_err_invalid), .err_cnt(b_err_cnt));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic inst_t mkInst(input logic [3:0] op, input logic mode, input logic immSel,
                                   input logic sub, input logic [3:0] r, input logic [3:0] s,
                                   input logic [3:0] u, input logic [11:0] i);
    inst_t t;
    t = '{op: op, mode: mode, imm_sel: immSel, sub: sub, spec_sel: 1'b0, r: r, s: s, u: u, i: i};
    return t;
  endfunction

  // Presents inputs across one rising edge, then returns 1 time unit later with in_vld/flush dropped.
  task automatic applyStimulus(input logic vld, input inst_t inst, input logic [7:0] pc,
                               input logic ordy, input logic fl);
    in_vld  = vld;
    in_inst = inst;
    in_pc   = pc;
    out_rdy = ordy;
    flush   = fl;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    flush  = 1'b0;
  endtask

  inst_t subInst, movInst, badInst, callInst, retInst;

  initial begin
    subInst  = mkInst(OP_ARITH, 1'b1, 1'b0, 1'b1, 4'd3, 4'd4, 4'd5, 12'h000);
    movInst  = mkInst(OP_MOV,   1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 12'h055);
    badInst  = mkInst(4'd8,     1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 12'h000);
    callInst = mkInst(OP_CRET,  1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'h010);
    retInst  = mkInst(OP_CRET,  1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'h020);

    rst = 1'b1; in_vld = 1'b0; in_inst = '0; in_pc = '0; out_rdy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstInRdy", in_rdy, 1);
    checkOutput("rstOutVld", out_vld, 0);
    checkOutput("rstUcode", out_ucode, 0);
    checkOutput("rstPc", out_pc, 0);
    checkOutput("rstOcc", occupancy, 0);
    checkOutput("rstErrInv", err_invalid, 0);
    checkOutput("rstErrCnt", err_cnt, 0);
    rst = 1'b0;

    applyStimulus(1'b1, subInst, 8'h10, 1'b0, 1'b0);
    checkOutput("subVld", out_vld, 1);
    checkOutput("subPc", out_pc, 8'h10);
    checkOutput("subFlags", {out_ucode.dst_en, out_ucode.flag_en, out_ucode.src0_en,
                             out_ucode.src1_en, out_ucode.inv_src1, out_ucode.cin}, 6'b111111);
    checkOutput("subHasImm", out_ucode.has_imm, 0);
    checkOutput("subDst", out_ucode.dst, 3);
    checkOutput("subOcc", occupancy, 1);
    applyStimulus(1'b0, subInst, 8'h00, 1'b1, 1'b0);
    checkOutput("subPopOcc", occupancy, 0);
    checkOutput("subPopVld", out_vld, 0);
    checkOutput("subPopUcode", out_ucode, 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, movInst, 8'h20 + 8'(i), 1'b0, 1'b0);
      if (i == 2) checkOutput("fillRdy3", in_rdy, 1);
      if (i == 3) checkOutput("fillRdy4", in_rdy, 0);
    end
    checkOutput("fullOcc", occupancy, 4);
    checkOutput("fullHead", out_pc, 8'h20);
    checkOutput("movFlags", {out_ucode.has_imm, out_ucode.dst_en, out_ucode.src0_is_zero,
                             out_ucode.src1_en}, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainHead", out_pc, 8'h20 + 8'(i));
      if (i == 0) begin
        in_vld = 1'b1; out_rdy = 1'b1; #1;
        checkOutput("fullPopNoRdy", in_rdy, 0);
      end
      applyStimulus(i == 0, movInst, 8'h99, 1'b1, 1'b0);
      if (i == 0) checkOutput("fullPopOcc", occupancy, 3);
    end
    checkOutput("drainOcc", occupancy, 0);
    checkOutput("drainVld", out_vld, 0);

    applyStimulus(1'b1, movInst, 8'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, movInst, 8'h31, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("steadyHead", out_pc, 8'h30 + 8'(i));
      applyStimulus(1'b1, movInst, 8'h32 + 8'(i), 1'b1, 1'b0);
      checkOutput("steadyOcc", occupancy, 2);
    end
    checkOutput("steadyTail0", out_pc, 8'h3A);
    applyStimulus(1'b0, movInst, 8'h00, 1'b1, 1'b0);
    checkOutput("steadyTail1", out_pc, 8'h3B);
    applyStimulus(1'b0, movInst, 8'h00, 1'b1, 1'b0);
    checkOutput("steadyEmpty", occupancy, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, badInst, 8'h70 + 8'(i), 1'b0, 1'b0);
    checkOutput("dropOcc", occupancy, 0);
    checkOutput("dropVld", out_vld, 0);
    checkOutput("dropErrInv", err_invalid, 1);
    checkOutput("dropErrCnt3", err_cnt, 3);
    checkOutput("keepOcc3", b_occupancy, 3);
    for (int i = 3; i < 6; i++) applyStimulus(1'b1, badInst, 8'h70 + 8'(i), 1'b0, 1'b0);
    checkOutput("dropErrSat", err_cnt, 3);
    checkOutput("dropOcc2", occupancy, 0);
    checkOutput("keepOcc4", b_occupancy, 4);
    checkOutput("keepErrCnt", b_err_cnt, 4);
    checkOutput("keepInvFlag", b_out_ucode.invalid_inst, 1);
    checkOutput("keepHeadPc", b_out_pc, 8'h70);
    applyStimulus(1'b0, badInst, 8'h00, 1'b0, 1'b1);
    checkOutput("keepFlushOcc", b_occupancy, 0);
    checkOutput("keepFlushErr", b_err_cnt, 4);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, movInst, 8'h40 + 8'(i), 1'b0, 1'b0);
    checkOutput("preFlushOcc", occupancy, 3);
    applyStimulus(1'b1, callInst, 8'h50, 1'b0, 1'b1);
    checkOutput("flushOcc", occupancy, 0);
    checkOutput("flushVld", out_vld, 0);
    checkOutput("flushRdy", in_rdy, 1);
    checkOutput("flushErrCnt", err_cnt, 3);
    applyStimulus(1'b0, callInst, 8'h00, 1'b0, 1'b0);
    checkOutput("flushNoCall", out_vld, 0);
    checkOutput("flushPc", out_pc, 0);

    applyStimulus(1'b1, callInst, 8'h51, 1'b0, 1'b0);
    checkOutput("callPc", out_pc, 8'h51);
    checkOutput("callDst", out_ucode.dst, BLINK);
    checkOutput("callFlags", {out_ucode.dst_en, out_ucode.is_jump, out_ucode.src0_is_zero,
                              out_ucode.src1_en}, 4'b1110);
    applyStimulus(1'b0, callInst, 8'h00, 1'b1, 1'b0);
    checkOutput("callPopOcc", occupancy, 0);

    in_vld = 1'b1; in_inst = retInst; in_pc = 8'h60; out_rdy = 1'b1;
    #2;
`ifdef QS_SRT_DECODE_Q_BYPASS_EN
    checkOutput("retBypVld", out_vld, 1);
    checkOutput("retBypSrc1", out_ucode.src1, BLINK);
    checkOutput("retBypBlink", out_ucode.src1_is_blink, 1);
    checkOutput("retBypPc", out_pc, 8'h60);
    checkOutput("retBypOcc", occupancy, 0);
    @(posedge clk); #1; in_vld = 1'b0;
    #1;
    checkOutput("retBypOccAfter", occupancy, 0);
    checkOutput("retBypVldAfter", out_vld, 0);
`else
    checkOutput("retSameCycVld", out_vld, 0);
    @(posedge clk); #1; in_vld = 1'b0;
    #1;
    checkOutput("retVld", out_vld, 1);
    checkOutput("retSrc1", out_ucode.src1, BLINK);
    checkOutput("retBlink", {out_ucode.src1_is_blink, out_ucode.src1_en, out_ucode.is_jump}, 3'b111);
    checkOutput("retOcc", occupancy, 1);
    @(posedge clk); #1;
    checkOutput("retPopOcc", occupancy, 0);
`endif

    applyStimulus(1'b1, movInst, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, movInst, 8'h81, 1'b0, 1'b0);
    checkOutput("preRstOcc", occupancy, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncOcc", occupancy, 0);
    checkOutput("asyncVld", out_vld, 0);
    checkOutput("asyncPc", out_pc, 0);
    checkOutput("asyncErrCnt", err_cnt, 0);
    checkOutput("asyncErrInv", err_invalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, movInst, 8'h00, 1'b0, 1'b0);
    checkOutput("postRstRdy", in_rdy, 1);
    checkOutput("postRstVld", out_vld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/qs_srt_decode_queue.md
# qs_srt_decode_queue

Parametrised decode-and-buffer stage for the qs_srt microsequencer. It accepts raw `qs_srt_pkg::inst_t` words with a program counter over a valid/ready handshake and decodes them to `qs_srt_pkg::ucode_t`. Decoded entries are held in a DEPTH-entry FIFO and presented to the issue stage over a second valid/ready handshake. It adds flush, occupancy reporting, invalid-instruction accounting and an optional drop mode, and sits between instruction fetch and issue.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_W, 8, program-counter width carried alongside each entry
- ERR_CNT_W, 8, width of the saturating invalid-instruction counter
- DROP_INVALID, 0, 1: invalid instructions are consumed and counted but never enqueued
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_vld  in  1  instruction valid
- in_inst  in  inst_t  raw instruction
- in_pc  in  PC_W  PC of in_inst
- in_rdy  out  1  queue can accept
- out_vld  out  1  head entry valid
- out_ucode  out  ucode_t  decoded head entry
- out_pc  out  PC_W  PC of head entry
- out_rdy  in  1  issue consumes head
- flush  in  1  discard all queued entries
- occupancy  out  $clog2(DEPTH+1)  entries held
- err_invalid  out  1  sticky: an invalid opcode has been accepted since reset
- err_cnt  out  ERR_CNT_W  count of invalid opcodes accepted, saturating

## Operation
- Decode is combinational on in_inst, per qs_srt_pkg field accessors (I/R/S/U/SPECIAL/CC/A into imm/dst/src0/src1/special/cc/target).
- Opcode behaviour: NOP, all enables 0. JCC: is_jump. PP: pop (dst_en) or push (src1_en, src0_is_zero) by SEL. MEM: src1_en, plus store (src0_en) or load (dst_en). MOV: dst_en, src0_is_zero, with src1_en / has_imm / has_special. ARITH: dst_en=W, flag_en, src0_en, has_imm or src1_en; SUB sets inv_src1 and cin. CRET: is_jump, src0_is_zero; RET sets src1=BLINK and src1_en, CALL sets dst=BLINK and dst_en. CNTRL: is_done / is_await. Any other opcode sets invalid_inst.
- src0_is_blink = src0_en & src0==BLINK; src1_is_blink likewise.
- Push occurs when in_vld & in_rdy & !flush, and not (DROP_INVALID & invalid_inst). Pop occurs when out_vld & out_rdy & !flush.
- in_rdy = (occupancy != DEPTH). There is no pass-through when full; a pop in the same cycle does not raise in_rdy.
- Storage is a circular buffer with log2(DEPTH)-bit read/write pointers that wrap naturally. Simultaneous push and pop leaves occupancy unchanged.
- err_cnt increments on every accepted (in_vld & in_rdy) invalid instruction, including dropped ones and those accepted in a flush cycle. It saturates at all-ones. err_invalid sets with the first such increment.
- flush: next cycle occupancy=0, pointers=0, out_vld=0. A handshake in the flush cycle is accepted on the input side but discarded. flush does not clear err_cnt or err_invalid.

## Timing
- Reset values: in_rdy=1, out_vld=0, out_ucode=0, out_pc=0, occupancy=0, err_invalid=0, err_cnt=0.
- Reset is asynchronous. Assertion mid-operation empties the queue immediately; no partial entry survives.
- Accept-to-out_vld latency is 1 cycle; a pop-to-next-head update is visible in the following cycle.
- out_ucode and out_pc are driven from registered storage; they are 0 whenever out_vld=0.
- Throughput is 1 entry/cycle when 0 < occupancy < DEPTH.
- out_vld and its payload stay stable until popped or flushed.

## Configuration
- QS_SRT_DECODE_Q_BYPASS_EN defined: when occupancy=0, in_vld=1, out_rdy=1 and the entry would be pushed, the decoded entry is driven combinationally to out_* with out_vld=1 in the same cycle and is not written. In that case occupancy and pointers are unchanged. A dropped invalid instruction never bypasses.
- Undefined: there is no combinational in-to-out path; minimum latency is 1 cycle.

## Test plan
- Reset, then push ARITH SUB (W=1, IMM=0) at pc=0x10 with out_rdy=0 -> next cycle out_vld=1, out_pc=0x10, dst_en/flag_en/src0_en/src1_en/inv_src1/cin=1, occupancy=1.
- DEPTH=4, out_rdy=0, push 5 back-to-back -> in_rdy=0 after the 4th accept, 5th held; occupancy=4; draining yields PCs in order with pointer wrap.
- Occupancy=2, simultaneous push and pop every cycle for 10 cycles -> occupancy stays 2, order preserved.
- Push 3 invalid opcodes with ERR_CNT_W=2 and DROP_INVALID=1, then 3 more -> no entries enqueued, out_vld=0, err_invalid=1, err_cnt=3 (saturated).
- Occupancy=3, assert flush together with an input handshake of CALL -> next cycle occupancy=0, out_vld=0, CALL not present, err_cnt unchanged.
- With QS_SRT_DECODE_Q_BYPASS_EN, empty queue, out_rdy=1, push RET -> same cycle out_vld=1, src1=BLINK, src1_is_blink=1; occupancy stays 0. Without the macro -> out_vld asserts one cycle later.
